// File: rtl/i2c_slave_regbank.sv
// I2C target with an internal bank of NUM_REGS 8-bit registers, oversampled on CLOCK.
// Optional macro I2C_REGBANK_AUTO_INC_EN: pointer auto-increments after each ACKed data byte.
module i2c_slave_regbank #(
  parameter logic [7:0] I2C_SLAVE_ADDR = 8'h78,
  parameter int         NUM_REGS       = 16,
  parameter int         REG_ADDR_W     = 4,
  parameter int         FILTER_LEN     = 3
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  SCL,
  inout  wire                   SDA,
  input  logic [REG_ADDR_W-1:0] REG_RD_ADDR,
  output logic [7:0]            REG_RD_DATA,
  output logic                  WR_STB,
  output logic [REG_ADDR_W-1:0] WR_ADDR,
  output logic [7:0]            WR_DATA,
  output logic                  BUSY
);

  localparam int          CNT_W      = $clog2(FILTER_LEN + 1);
  localparam int          SETTLE_W   = $clog2(FILTER_LEN + 4);
  localparam logic [8:0]  NUM_REGS_L = 9'(NUM_REGS);
  localparam logic [6:0]  DEV_ADDR7  = I2C_SLAVE_ADDR[7:1];

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_PTR, PTR_ACK,
    WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  // line index 0 = SCL, 1 = SDA
  logic [1:0]            sync1_q, sync2_q, filt_q, prev_q;
  logic [CNT_W-1:0]      fcnt_q [2];
  logic [SETTLE_W-1:0]   settle_q;
  logic                  rise_d1_q, fall_d1_q;

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic [REG_ADDR_W-1:0] ptr_q, ptr_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  ack_phase_q, ack_phase_d;
  logic                  rd_first_q, rd_first_d;
  logic                  busy_q, busy_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic [7:0]            bank_q [NUM_REGS];

  logic                  armed_s, start_s, stop_s, sample_s, fall_s, bank_we_s;
  logic [7:0]            in_byte_s;
  logic [REG_ADDR_W-1:0] ptr_inc_s, ptr_next_s;

  // Synchronise, filter and edge-detect both bus lines
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      prev_q    <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
      settle_q  <= '0;
      rise_d1_q <= 1'b0;
      fall_d1_q <= 1'b0;
    end else begin
      sync1_q   <= {SDA, SCL};
      sync2_q   <= sync1_q;
      prev_q    <= filt_q;
      rise_d1_q <= filt_q[0] & ~prev_q[0];
      fall_d1_q <= ~filt_q[0] & prev_q[0];
      if (!armed_s) settle_q <= settle_q + SETTLE_W'(1);
      else          settle_q <= settle_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edges on filtered lines are ignored until the pipeline has flushed after reset
  assign armed_s   = (settle_q == SETTLE_W'(FILTER_LEN + 3));
  assign start_s   = armed_s & prev_q[1] & ~filt_q[1] & prev_q[0] & filt_q[0];
  assign stop_s    = armed_s & ~prev_q[1] & filt_q[1] & prev_q[0] & filt_q[0];
  assign sample_s  = rise_d1_q;
  assign fall_s    = fall_d1_q;
  assign in_byte_s = {shift_q[6:0], filt_q[1]};

  assign ptr_inc_s = (ptr_q == REG_ADDR_W'(NUM_REGS - 1)) ? '0 : ptr_q + REG_ADDR_W'(1);
`ifdef I2C_REGBANK_AUTO_INC_EN
  assign ptr_next_s = ptr_inc_s;
`else
  assign ptr_next_s = ptr_q;
`endif

  // FSM next-state, shifter, pointer and output decode
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    ack_phase_d = ack_phase_q;
    rd_first_d  = rd_first_q;
    busy_d      = busy_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    bank_we_s   = 1'b0;

    if (stop_s) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
      rd_first_d  = 1'b0;
    end else if (start_s) begin
      state_d     = DEV_ADDR;
      bit_cnt_d   = 3'd7;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
      rd_first_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: sda_oe_d = 1'b0;
        DEV_ADDR, REG_PTR, WR_BYTE: begin
          if (sample_s) begin
            shift_d   = in_byte_s;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              if (state_q == DEV_ADDR) begin
                state_d = (in_byte_s[7:1] == DEV_ADDR7) ? DEV_ACK : IGNORE;
                busy_d  = (in_byte_s[7:1] == DEV_ADDR7);
              end else if (state_q == REG_PTR) begin
                if ({1'b0, in_byte_s} < NUM_REGS_L) begin
                  ptr_d   = in_byte_s[REG_ADDR_W-1:0];
                  state_d = PTR_ACK;
                end else begin
                  state_d = IGNORE;
                end
              end else begin
                bank_we_s = 1'b1;
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = in_byte_s;
                state_d   = WR_ACK;
              end
            end else begin
              state_d = state_q;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        DEV_ACK, PTR_ACK, WR_ACK: begin
          // First SCL fall starts driving the ACK low, second one ends it
          if (fall_s) begin
            ack_phase_d = ~ack_phase_q;
            if (!ack_phase_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd7;
              if (state_q == DEV_ACK && shift_q[0]) begin
                state_d  = RD_BYTE;
                shift_d  = bank_q[ptr_q];
                sda_oe_d = ~bank_q[ptr_q][7];
              end else if (state_q == DEV_ACK) begin
                state_d = REG_PTR;
              end else begin
                state_d = WR_BYTE;
                ptr_d   = (state_q == WR_ACK) ? ptr_next_s : ptr_q;
              end
            end
          end else begin
            ack_phase_d = ack_phase_q;
          end
        end
        RD_BYTE: begin
          if (fall_s) begin
            if (rd_first_q) begin
              sda_oe_d   = ~shift_q[7];
              rd_first_d = 1'b0;
            end else if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
            end
          end else begin
            shift_d = shift_q;
          end
        end
        RD_ACK: begin
          if (sample_s) begin
            if (!filt_q[1]) begin
              ptr_d      = ptr_next_s;
              shift_d    = bank_q[ptr_next_s];
              bit_cnt_d  = 3'd7;
              rd_first_d = 1'b1;
              state_d    = RD_BYTE;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            state_d = RD_ACK;
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    if (state_d == IDLE || state_d == IGNORE) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_d;
    end
  end

  // FSM and output registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      ack_phase_q <= 1'b0;
      rd_first_q  <= 1'b0;
      busy_q      <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      ack_phase_q <= ack_phase_d;
      rd_first_q  <= rd_first_d;
      busy_q      <= busy_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Register bank storage
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= 8'h00;
    end else if (bank_we_s) begin
      bank_q[ptr_q] <= in_byte_s;
    end else begin
      bank_q[ptr_q] <= bank_q[ptr_q];
    end
  end

  assign SDA         = sda_oe_q ? 1'b0 : 1'bz;
  assign REG_RD_DATA = (int'(REG_RD_ADDR) < NUM_REGS) ? bank_q[REG_RD_ADDR] : 8'h00;
  assign WR_STB      = wr_stb_q;
  assign WR_ADDR     = wr_addr_q;
  assign WR_DATA     = wr_data_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Directed bench for i2c_slave_regbank: bit-banged I2C master, WR_STB monitor, fabric read checks.
module tb_i2c_slave_regbank;

  localparam int HP = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_rel = 1'b1;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  wire        sda_w;

  int total = 0;
  int bad = 0;
  int stb_cnt = 0;
  logic [3:0] stb_addr = 4'd0;
  logic [7:0] stb_data = 8'h00;

  pullup (sda_w);
  assign sda_w = sda_rel ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_slave_regbank dut (
    .CLOCK(clk), .RESET(rst_n), .SCL(scl_m), .SDA(sda_w),
    .REG_RD_ADDR(rd_addr), .REG_RD_DATA(rd_data),
    .WR_STB(wr_stb), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .BUSY(busy)
  );

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_cnt  <= stb_cnt + 1;
      stb_addr <= wr_addr;
      stb_data <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_rel = 1'b1; cyc(HP);
    scl_m = 1'b1;   cyc(HP);
    sda_rel = 1'b0; cyc(HP);
    scl_m = 1'b0;   cyc(4);
  endtask

  task automatic i2c_stop();
    sda_rel = 1'b0; cyc(HP);
    scl_m = 1'b1;   cyc(HP);
    sda_rel = 1'b1; cyc(HP);
  endtask

  task automatic write_bit(input logic b);
    sda_rel = b;  cyc(HP);
    scl_m = 1'b1; cyc(HP);
    scl_m = 1'b0; cyc(4);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_rel = 1'b1; cyc(HP);
    scl_m = 1'b1;   cyc(HP / 2);
    ack = sda_w;    cyc(HP / 2);
    scl_m = 1'b0;   cyc(4);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    sda_rel = 1'b1;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cyc(HP);
      scl_m = 1'b1; cyc(HP / 2);
      b = {b[6:0], sda_w};
      cyc(HP / 2);
      scl_m = 1'b0; cyc(4);
    end
    write_bit(ack_bit);
    sda_rel = 1'b1;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp_v);
    rd_addr = a;
    #1;
    check(tag, {24'h0, rd_data}, {24'h0, exp_v});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         base;
    logic [7:0] exp_ptr_rd;

    // Reset state
    cyc(5);
    #1;
    check("rst_sda", {31'h0, sda_w}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 16; i++) rd_check("rst_bank", 4'(i), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(20);

    // Single write: reg4 = 0x4A
    base = stb_cnt;
    i2c_start();
    write_byte(8'h78, ack); check("wr_dev_ack", {31'h0, ack}, 32'h0);
    check("wr_busy", {31'h0, busy}, 32'h1);
    write_byte(8'h04, ack); check("wr_ptr_ack", {31'h0, ack}, 32'h0);
    write_byte(8'h4A, ack); check("wr_dat_ack", {31'h0, ack}, 32'h0);
    i2c_stop();
    check("wr_stb_cnt", stb_cnt - base, 32'd1);
    check("wr_stb_addr", {28'h0, stb_addr}, 32'h4);
    check("wr_stb_data", {24'h0, stb_data}, 32'h4A);
    rd_check("wr_reg4", 4'd4, 8'h4A);
    check("wr_busy_idle", {31'h0, busy}, 32'h0);

    // Pointer set, repeated START, read one byte with NACK
    base = stb_cnt;
    i2c_start();
    write_byte(8'h78, ack); check("rd_dev_ack", {31'h0, ack}, 32'h0);
    write_byte(8'h04, ack); check("rd_ptr_ack", {31'h0, ack}, 32'h0);
    i2c_start();
    write_byte(8'h79, ack); check("rd_devr_ack", {31'h0, ack}, 32'h0);
    check("rd_busy", {31'h0, busy}, 32'h1);
    read_byte(1'b1, rb);
    check("rd_data", {24'h0, rb}, 32'h4A);
    check("rd_busy_nack", {31'h0, busy}, 32'h0);
    i2c_stop();
    check("rd_no_stb", stb_cnt - base, 32'd0);

    // Wrong device address
    base = stb_cnt;
    i2c_start();
    write_byte(8'h7A, ack); check("bad_dev_nack", {31'h0, ack}, 32'h1);
    check("bad_busy", {31'h0, busy}, 32'h0);
    write_byte(8'h04, ack); check("bad_ptr_z", {31'h0, ack}, 32'h1);
    write_byte(8'h55, ack); check("bad_dat_z", {31'h0, ack}, 32'h1);
    i2c_stop();
    check("bad_no_stb", stb_cnt - base, 32'd0);
    rd_check("bad_reg4", 4'd4, 8'h4A);

    // Burst write at 0x0F
    base = stb_cnt;
    i2c_start();
    write_byte(8'h78, ack); check("bu_dev_ack", {31'h0, ack}, 32'h0);
    write_byte(8'h0F, ack); check("bu_ptr_ack", {31'h0, ack}, 32'h0);
    write_byte(8'h11, ack); check("bu_d0_ack", {31'h0, ack}, 32'h0);
    write_byte(8'h22, ack); check("bu_d1_ack", {31'h0, ack}, 32'h0);
    i2c_stop();
    check("bu_stb_cnt", stb_cnt - base, 32'd2);
`ifdef I2C_REGBANK_AUTO_INC_EN
    rd_check("bu_reg15", 4'd15, 8'h11);
    rd_check("bu_reg0", 4'd0, 8'h22);
    check("bu_last_addr", {28'h0, stb_addr}, 32'h0);
    exp_ptr_rd = 8'h00;
`else
    rd_check("bu_reg15", 4'd15, 8'h22);
    rd_check("bu_reg0", 4'd0, 8'h00);
    check("bu_last_addr", {28'h0, stb_addr}, 32'hF);
    exp_ptr_rd = 8'h22;
`endif

    // Out-of-range pointer
    base = stb_cnt;
    i2c_start();
    write_byte(8'h78, ack); check("oor_dev_ack", {31'h0, ack}, 32'h0);
    write_byte(8'h10, ack); check("oor_ptr_nack", {31'h0, ack}, 32'h1);
    check("oor_busy", {31'h0, busy}, 32'h0);
    write_byte(8'h99, ack); check("oor_dat_z", {31'h0, ack}, 32'h1);
    i2c_stop();
    check("oor_no_stb", stb_cnt - base, 32'd0);
    rd_check("oor_reg4", 4'd4, 8'h4A);
    i2c_start();
    write_byte(8'h79, ack); check("oor_rd_ack", {31'h0, ack}, 32'h0);
    read_byte(1'b1, rb);
    check("oor_ptr_kept", {24'h0, rb}, {24'h0, exp_ptr_rd});
    i2c_stop();

    // Reset while the target drives the first (0) data bit of a read
    base = stb_cnt;
    i2c_start();
    write_byte(8'h79, ack); check("mr_dev_ack", {31'h0, ack}, 32'h0);
    cyc(HP);
    scl_m = 1'b1; cyc(HP / 2);
    check("mr_drive_low", {31'h0, sda_w}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mr_sda_z", {31'h0, sda_w}, 32'h1);
    check("mr_busy", {31'h0, busy}, 32'h0);
    rd_check("mr_reg4", 4'd4, 8'h00);
    rd_check("mr_reg15", 4'd15, 8'h00);
    cyc(10);
    rst_n = 1'b1;
    cyc(20);
    i2c_start();
    write_byte(8'h78, ack); check("mr2_dev_ack", {31'h0, ack}, 32'h0);
    write_byte(8'h02, ack); check("mr2_ptr_ack", {31'h0, ack}, 32'h0);
    write_byte(8'h5C, ack); check("mr2_dat_ack", {31'h0, ack}, 32'h0);
    i2c_stop();
    check("mr2_stb_cnt", stb_cnt - base, 32'd1);
    check("mr2_stb_data", {24'h0, stb_data}, 32'h5C);
    rd_check("mr2_reg2", 4'd2, 8'h5C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regbank.md
Name: i2c_slave_regbank

Overview:
- Parametrised successor to the existing I2C_SLAVE: an I2C target with an internal bank of NUM_REGS 8-bit registers.
- Supports multi-byte writes and reads, repeated START, an out-of-range pointer NACK, and a fabric-side register read port and write strobe.
- Sits between the board-level SDA/SCL pins and the control-register consumers.
- Oversamples the bus with the system clock; no SCL-domain logic.

Parameters:
- I2C_SLAVE_ADDR, 8'h78: 8-bit write-form device address. Bit 0 is ignored; the 7-bit address is I2C_SLAVE_ADDR[7:1].
- NUM_REGS, 16: number of registers, 1..256.
- REG_ADDR_W, 4: pointer width; must satisfy 2^REG_ADDR_W >= NUM_REGS.
- FILTER_LEN, 3: CLOCK cycles SCL/SDA must be stable before a new level is accepted.

Ports:
- CLOCK  in  1  system clock (180 MHz nominal)
- RESET  in  1  asynchronous active-low reset
- SCL  in  1  I2C clock (target never stretches)
- SDA  inout  1  I2C data, open-drain: drives 0 or Z only
- REG_RD_ADDR  in  REG_ADDR_W  fabric read index
- REG_RD_DATA  out  8  combinational read of bank[REG_RD_ADDR]
- WR_STB  out  1  1-cycle pulse when a bus write commits a byte
- WR_ADDR  out  REG_ADDR_W  register index written; valid with WR_STB
- WR_DATA  out  8  byte written; valid with WR_STB
- BUSY  out  1  high from an addressed START until STOP or NACK

Behaviour:
- Input conditioning:
  - 2-FF synchroniser, then a FILTER_LEN stability filter per line.
  - Edge detect on the filtered values.
  - START = SDA falls while SCL high; STOP = SDA rises while SCL high.
- Timing: sample SDA one cycle after the filtered SCL rise; change SDA one cycle after the filtered SCL fall.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- IDLE: START -> DEV_ADDR, bit counter = 7.
- DEV_ADDR: shift 8 bits MSB-first.
  - Byte[7:1] matches -> DEV_ACK; otherwise -> IGNORE (SDA stays Z).
- DEV_ACK: drive 0 for one SCL period.
  - R/W=0 -> REG_PTR.
  - R/W=1 -> RD_BYTE, loading shift register from bank[ptr].
- REG_PTR: receive byte.
  - Byte < NUM_REGS: ptr <= byte[REG_ADDR_W-1:0], ACK in PTR_ACK, then -> WR_BYTE.
  - Otherwise: NACK (SDA Z), ptr unchanged, -> IGNORE.
- WR_BYTE: receive byte.
  - At the 8th SCL rise: bank[ptr] <= byte, WR_STB=1 for exactly one CLOCK, WR_ADDR=ptr, WR_DATA=byte.
  - Then ACK in WR_ACK, pointer update (see Optional Feature), -> WR_BYTE.
- RD_BYTE: drive bit MSB-first (0 -> drive low, 1 -> Z).
  - After the 8th SCL fall, release SDA -> RD_ACK.
- RD_ACK: sample the master's bit.
  - 0 (ACK): pointer update, load next byte, -> RD_BYTE.
  - 1 (NACK): -> IGNORE.
- Any state: STOP -> IDLE; START -> DEV_ADDR (repeated START). Both take priority over bit processing in the same cycle. The pointer is retained across transactions.
- A write in progress at STOP/START with fewer than 8 bits received is discarded (no WR_STB).
- BUSY: set on entering DEV_ACK with a match; cleared in IDLE and IGNORE.
- Reset (asserted at any time, including mid-transfer):
  - Bank all 0x00, ptr=0, state IDLE, SDA released (Z), WR_STB=0, WR_ADDR=0, WR_DATA=0, BUSY=0.
  - Bus activity resumes only at the next START.
- Reading beyond NUM_REGS cannot occur: the pointer is always in range.

Optional Feature:
- Macro I2C_REGBANK_AUTO_INC_EN.
- Defined: the pointer increments after every ACKed data byte (write or read), wrapping from NUM_REGS-1 to 0.
- Undefined: the pointer is held; repeated bytes in one transaction all target the same register.

Test Plan:
- Reset -> SDA Z, BUSY=0, REG_RD_DATA=0x00 for all REG_RD_ADDR values.
- Write: START, 0x78, 0x04, 0x4A, STOP.
  - Target ACKs all three bytes.
  - WR_STB pulses once with WR_ADDR=4, WR_DATA=0x4A.
  - REG_RD_ADDR=4 -> 0x4A.
- Pointer-set then repeated START read: START, 0x78, 0x04, Sr, 0x79, read 1 byte, NACK, STOP.
  - SDA carries 0x4A.
  - BUSY falls after the NACK.
- Wrong address 0x7A -> no ACK (SDA Z for the whole frame), no WR_STB, BUSY=0.
- Burst write 0x0F: 0x11, 0x22.
  - With AUTO_INC_EN: reg15=0x11, reg0=0x22 (wrap).
  - Without: reg15=0x22.
- Pointer 0x10 (NUM_REGS=16) -> NACK on the pointer byte, bank unchanged.
- RESET asserted mid data byte -> SDA Z immediately, all state cleared, next full transaction works.
